// File: rtl/verin_sample_logger.sv
// Sample logger: an Avalon-MM write master that streams 32-bit actuator
// samples from a valid/ready interface into a single-port on-chip RAM.
// It supports a one-shot capture of N words or a circular buffer, and it
// reports busy/done/wrapped/config-error status and a valid-word count.
module verin_sample_logger #(
   parameter int DEPTH = 5000,
   parameter int AW    = 13,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          stop,
   input  logic          wrap_en,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] length,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic [AW-1:0] m_address,
   output logic [3:0]    m_byteenable,
   output logic          m_chipselect,
   output logic          m_write,
   output logic [DW-1:0] m_writedata,
   output logic          m_clken,
   output logic          busy,
   output logic          done,
   output logic          wrapped,
   output logic          cfg_err,
   output logic [AW-1:0] word_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;

   logic [AW-1:0] base_q;
   logic [AW-1:0] len_q;
   logic          wrap_q;
   logic [AW-1:0] offset;

   logic [AW:0]   cfg_end;
   logic          cfg_ok;
   logic          can_start;
   logic          accept;
   logic          reject;
   logic          handshake;
   logic          last_word;

   // The RAM is always selected for full-word access and never clock-gated.
   assign m_byteenable = 4'hF;
   assign m_clken      = 1'b1;

   // The end of the buffer is computed one bit wider so base+length cannot
   // silently wrap past the top of the address space.
   assign cfg_end   = {1'b0, base_addr} + {1'b0, length};
   assign cfg_ok    = (length != '0) && (cfg_end <= (AW+1)'(DEPTH));
   assign can_start = start && ((state == IDLE) || (state == DONE));
   assign accept    = can_start && cfg_ok;
   assign reject    = can_start && !cfg_ok;
   assign handshake = s_valid && (state == RUN);
   assign last_word = (offset == (len_q - 1'b1));

   // State register; reset aborts any capture in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection and state-decoded status outputs.
   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = RUN;
            end
         end
         RUN: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (stop || (handshake && last_word && !wrap_q)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            busy       = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (accept) begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Write pipeline, buffer bookkeeping and sticky status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_write      <= 1'b0;
         m_chipselect <= 1'b0;
         m_address    <= '0;
         m_writedata  <= '0;
         offset       <= '0;
         word_count   <= '0;
         wrapped      <= 1'b0;
         cfg_err      <= 1'b0;
         base_q       <= '0;
         len_q        <= '0;
         wrap_q       <= 1'b0;
      end else begin
         m_write      <= handshake;
         m_chipselect <= handshake;
         if (handshake) begin
            m_address   <= base_q + offset;
            m_writedata <= s_data;
            if (last_word) begin
               offset <= '0;
               if (wrap_q) begin
                  wrapped <= 1'b1;
               end
            end else begin
               offset <= offset + 1'b1;
            end
            if (word_count != len_q) begin
               word_count <= word_count + 1'b1;
            end
         end
         if (accept) begin
            cfg_err    <= 1'b0;
            wrapped    <= 1'b0;
            word_count <= '0;
            offset     <= '0;
            base_q     <= base_addr;
            len_q      <= length;
            wrap_q     <= wrap_en;
         end else if (reject) begin
            cfg_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_verin_sample_logger.sv
// Self-checking bench for the sample logger: a table of directed vectors
// with hand-computed expectations, plus a hand-written async-reset sequence.
module tb_verin_sample_logger;

   localparam int AW = 13;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          stop;
   logic          wrap_en;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] length;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [AW-1:0] m_address;
   logic [3:0]    m_byteenable;
   logic          m_chipselect;
   logic          m_write;
   logic [DW-1:0] m_writedata;
   logic          m_clken;
   logic          busy;
   logic          done;
   logic          wrapped;
   logic          cfg_err;
   logic [AW-1:0] word_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic          start;
      logic          stop;
      logic          wrap_en;
      logic [AW-1:0] base;
      logic [AW-1:0] len;
      logic          s_valid;
      logic [DW-1:0] s_data;
      logic          exp_write;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      logic          exp_ready;
      logic          exp_busy;
      logic          exp_done;
      logic          exp_wrapped;
      logic          exp_err;
      logic [AW-1:0] exp_wc;
   } vec_t;

   vec_t vecs[$];

   verin_sample_logger #(.DEPTH(5000), .AW(AW), .DW(DW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .stop         (stop),
      .wrap_en      (wrap_en),
      .base_addr    (base_addr),
      .length       (length),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .m_address    (m_address),
      .m_byteenable (m_byteenable),
      .m_chipselect (m_chipselect),
      .m_write      (m_write),
      .m_writedata  (m_writedata),
      .m_clken      (m_clken),
      .busy         (busy),
      .done         (done),
      .wrapped      (wrapped),
      .cfg_err      (cfg_err),
      .word_count   (word_count)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   function automatic vec_t mk(input int st, input int sp, input int wr,
                               input int b, input int l, input int sv,
                               input int sd, input int ew, input int ea,
                               input int ed, input int er, input int eb,
                               input int edn, input int ewr, input int ee,
                               input int ewc);
      vec_t v;
      v.start       = (st != 0);
      v.stop        = (sp != 0);
      v.wrap_en     = (wr != 0);
      v.base        = AW'(b);
      v.len         = AW'(l);
      v.s_valid     = (sv != 0);
      v.s_data      = DW'(sd);
      v.exp_write   = (ew != 0);
      v.exp_addr    = AW'(ea);
      v.exp_data    = DW'(ed);
      v.exp_ready   = (er != 0);
      v.exp_busy    = (eb != 0);
      v.exp_done    = (edn != 0);
      v.exp_wrapped = (ewr != 0);
      v.exp_err     = (ee != 0);
      v.exp_wc      = AW'(ewc);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      start     = v.start;
      stop      = v.stop;
      wrap_en   = v.wrap_en;
      base_addr = v.base;
      length    = v.len;
      s_valid   = v.s_valid;
      s_data    = v.s_data;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      chk({tag, " m_write"},      32'(m_write),      32'(v.exp_write));
      chk({tag, " m_chipselect"}, 32'(m_chipselect), 32'(v.exp_write));
      chk({tag, " m_address"},    32'(m_address),    32'(v.exp_addr));
      chk({tag, " m_writedata"},  m_writedata,       v.exp_data);
      chk({tag, " s_ready"},      32'(s_ready),      32'(v.exp_ready));
      chk({tag, " busy"},         32'(busy),         32'(v.exp_busy));
      chk({tag, " done"},         32'(done),         32'(v.exp_done));
      chk({tag, " wrapped"},      32'(wrapped),      32'(v.exp_wrapped));
      chk({tag, " cfg_err"},      32'(cfg_err),      32'(v.exp_err));
      chk({tag, " word_count"},   32'(word_count),   32'(v.exp_wc));
      chk({tag, " byteenable"},   32'(m_byteenable), 32'h0000_000F);
      chk({tag, " clken"},        32'(m_clken),      32'd1);
   endtask

   task automatic checkReset(input string tag);
      vec_t r;
      r = mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
      checkOutput(tag, r);
   endtask

   initial begin
      vec_t v;
      reset_n   = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      wrap_en   = 1'b0;
      base_addr = '0;
      length    = '0;
      s_data    = '0;
      s_valid   = 1'b0;
      #1;
      checkReset("reset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      //        st sp wr  base len  sv data     ew addr  data     rd bs dn wp er wc
      // One-shot base=100 length=4
      vecs.push_back(mk(1,0,0, 100,4,  0,0,      0,0,    0,       1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hA0,   1,100,  'hA0,    1,1,0,0,0,1));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hA1,   1,101,  'hA1,    1,1,0,0,0,2));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hA2,   1,102,  'hA2,    1,1,0,0,0,3));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hA3,   1,103,  'hA3,    0,1,0,0,0,4));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hA4,   0,103,  'hA3,    0,0,1,0,0,4));
      vecs.push_back(mk(0,0,0, 0,0,    0,0,      0,103,  'hA3,    0,0,1,0,0,4));
      // Circular buffer base=0 length=3, five samples then stop
      vecs.push_back(mk(1,0,1, 0,3,    0,0,      0,103,  'hA3,    1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hB0,   1,0,    'hB0,    1,1,0,0,0,1));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hB1,   1,1,    'hB1,    1,1,0,0,0,2));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hB2,   1,2,    'hB2,    1,1,0,1,0,3));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hB3,   1,0,    'hB3,    1,1,0,1,0,3));
      vecs.push_back(mk(0,1,0, 0,0,    1,'hB4,   1,1,    'hB4,    0,1,0,1,0,3));
      vecs.push_back(mk(0,0,0, 0,0,    0,0,      0,1,    'hB4,    0,0,1,1,0,3));
      // Rejected configs, then a start that exactly reaches the top word
      vecs.push_back(mk(1,0,0, 4998,3, 0,0,      0,1,    'hB4,    0,0,1,1,1,3));
      vecs.push_back(mk(1,0,0, 0,0,    0,0,      0,1,    'hB4,    0,0,1,1,1,3));
      vecs.push_back(mk(1,0,0, 4997,3, 0,0,      0,1,    'hB4,    1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hD0,   1,4997, 'hD0,    1,1,0,0,0,1));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hD1,   1,4998, 'hD1,    1,1,0,0,0,2));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hD2,   1,4999, 'hD2,    0,1,0,0,0,3));
      vecs.push_back(mk(0,0,0, 0,0,    0,0,      0,4999, 'hD2,    0,0,1,0,0,3));
      // Stop coincident with the second handshake; start during RUN ignored
      vecs.push_back(mk(1,0,0, 200,10, 0,0,      0,4999, 'hD2,    1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hE0,   1,200,  'hE0,    1,1,0,0,0,1));
      vecs.push_back(mk(1,0,1, 0,5,    0,0,      0,200,  'hE0,    1,1,0,0,0,1));
      vecs.push_back(mk(0,1,0, 0,0,    1,'hE1,   1,201,  'hE1,    0,1,0,0,0,2));
      vecs.push_back(mk(0,0,0, 0,0,    0,0,      0,201,  'hE1,    0,0,1,0,0,2));
      vecs.push_back(mk(0,1,0, 0,0,    0,0,      0,201,  'hE1,    0,0,1,0,0,2));
      // Gapped input stream
      vecs.push_back(mk(1,0,0, 50,8,   0,0,      0,201,  'hE1,    1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hF0,   1,50,   'hF0,    1,1,0,0,0,1));
      vecs.push_back(mk(0,0,0, 0,0,    0,'hFF,   0,50,   'hF0,    1,1,0,0,0,1));
      vecs.push_back(mk(0,0,0, 0,0,    1,'hF1,   1,51,   'hF1,    1,1,0,0,0,2));
      vecs.push_back(mk(0,0,0, 0,0,    0,'hFF,   0,51,   'hF1,    1,1,0,0,0,2));
      vecs.push_back(mk(0,1,0, 0,0,    0,0,      0,51,   'hF1,    0,1,0,0,0,2));
      vecs.push_back(mk(0,0,0, 0,0,    0,0,      0,51,   'hF1,    0,0,1,0,0,2));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i]);
      end

      // Async reset in the middle of a capture, then a fresh capture
      v = mk(1,0,0, 10,5, 0,0,     0,51,'hF1, 1,1,0,0,0,0);
      applyStimulus(v);
      checkOutput("rst_pre0", v);
      v = mk(0,0,0, 0,0,  1,'h11,  1,10,'h11, 1,1,0,0,0,1);
      applyStimulus(v);
      checkOutput("rst_pre1", v);
      v = mk(0,0,0, 0,0,  1,'h22,  1,11,'h22, 1,1,0,0,0,2);
      applyStimulus(v);
      checkOutput("rst_pre2", v);
      #2;
      reset_n = 1'b0;
      #1;
      checkReset("rst_mid");
      s_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkReset("rst_after");
      v = mk(1,0,1, 10,5, 0,0,     0,0,0,     1,1,0,0,0,0);
      applyStimulus(v);
      checkOutput("rst_post0", v);
      v = mk(0,0,0, 0,0,  1,'h77,  1,10,'h77, 1,1,0,0,0,1);
      applyStimulus(v);
      checkOutput("rst_post1", v);
      v = mk(0,1,0, 0,0,  0,0,     0,10,'h77, 0,1,0,0,0,1);
      applyStimulus(v);
      checkOutput("rst_post2", v);
      v = mk(0,0,0, 0,0,  0,0,     0,10,'h77, 0,0,1,0,0,1);
      applyStimulus(v);
      checkOutput("rst_post3", v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
